// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access controller.
//   state_e       : transaction FSM encoding
//   CMD_RW_BIT    : command-byte bit selecting write (1) or read (0)
//   BITS_PER_BYTE : SPI frame length
//   BIT_CNT_W     : width of the in-byte bit counter
//   MISO_IDLE     : level driven on miso when not returning data
package spi_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCmd  = 2'd1,
      StData = 2'd2
   } state_e;

   localparam int unsigned CMD_RW_BIT    = 7;
   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);
   localparam logic        MISO_IDLE     = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with single-cycle edge pulses.
//   clk  : system clock
//   rst  : asynchronous active-high reset (all stages cleared)
//   din  : asynchronous input
//   rise : one-clk pulse on a synchronized 0->1 transition
//   fall : one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Clearing to 0 on reset means a pin already low at release never yields a fall:
   // the line has to be seen high first.
   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave transaction controller running entirely in the system clock domain.
// The first byte of a frame is a command {rw, addr}; subsequent bytes are burst data
// written to / read from a local register bank with address auto-increment.
//   clk, rst   : system clock, asynchronous active-high reset
//   sclk, ce0  : SPI clock and active-low chip enable (asynchronous)
//   mosi, miso : serial data in / out, MSB first
//   reg_addr   : register bank address
//   reg_wdata  : write data, valid with reg_we
//   reg_we     : one-clk write strobe
//   reg_re     : one-clk read strobe; reg_rdata captured in that cycle
//   reg_rdata  : combinational read data for reg_addr
//   busy       : transaction in progress
//   xfer_done  : one-clk pulse on clean frame end
//   frame_err  : one-clk pulse when a frame ends mid-byte or before its command
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ce0,
   input  logic              mosi,
   output logic              miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              xfer_done,
   output logic              frame_err
);

   logic sclk_rise, sclk_fall, ce0_rise, ce0_fall;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ce0_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ce0),
      .rise (ce0_rise),
      .fall (ce0_fall)
   );

   // mosi needs only the level; same depth keeps it aligned with the sclk edge pulses.
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   mosi_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      end
   end

   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   state_e                 state_q, state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   // Only 7 bits are held: the 8th comes straight from mosi_s on the completing edge.
   logic [6:0]             rx_sh_q;
   logic [7:0]             tx_sh_q;
   logic                   rw_q;
   logic [ADDR_W-1:0]      reg_addr_q;
   logic [7:0]             reg_wdata_q;
   logic                   reg_we_q, reg_re_q, xfer_done_q, frame_err_q;

   logic                   active;
   logic [7:0]             rx_byte;
   logic                   byte_done, cmd_done, data_done;
   logic                   end_clean, end_err;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; ce0 release takes priority over byte completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (ce0_fall) state_d = StCmd;
         StCmd: begin
            if (ce0_rise) begin
               state_d = StIdle;
            end else if (byte_done) begin
               state_d = StData;
            end
         end
         StData: if (ce0_rise) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output / event decode
   always_comb begin
      active    = (state_q != StIdle);
      rx_byte   = {rx_sh_q, mosi_s};
      byte_done = active && sclk_rise && (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1));
      cmd_done  = (state_q == StCmd) && byte_done;
      data_done = (state_q == StData) && byte_done;
      // A byte completing in the same cycle as ce0 release counts as a whole byte.
      end_clean = active && ce0_rise &&
                  (((state_q == StData) && (bit_cnt_q == '0)) || byte_done);
      end_err   = active && ce0_rise && !end_clean;
      busy      = active;
      // Raw ce0 gates miso so the line drops as soon as the master deselects.
      miso      = ((state_q == StData) && !ce0) ? tx_sh_q[7] : MISO_IDLE;
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q   <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         rw_q        <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         xfer_done_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if ((!active && ce0_fall) || (active && ce0_rise)) begin
            bit_cnt_q <= '0;
         end else if (active && sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end

         if (!active && ce0_fall) begin
            rx_sh_q <= '0;
         end else if (active && sclk_rise) begin
            rx_sh_q <= rx_byte[6:0];
         end

         // The fall that ends a byte (counter back at 0) must not shift, or the freshly
         // loaded MSB would leave miso before the master samples it.
         if (!active && ce0_fall) begin
            tx_sh_q <= '0;
         end else if (reg_re_q) begin
            tx_sh_q <= reg_rdata;
         end else if ((state_q == StData) && sclk_fall && (bit_cnt_q != '0)) begin
            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
         end

         if (cmd_done) begin
            rw_q <= rx_byte[CMD_RW_BIT];
         end

         // Writes advance the address after the strobe; reads advance before the prefetch.
         if (cmd_done) begin
            reg_addr_q <= rx_byte[ADDR_W-1:0];
         end else if (reg_we_q || (data_done && !rw_q)) begin
            reg_addr_q <= reg_addr_q + 1'b1;
         end

         if (data_done && rw_q) begin
            reg_wdata_q <= rx_byte;
         end

         reg_we_q    <= data_done && rw_q;
         reg_re_q    <= (cmd_done && !rx_byte[CMD_RW_BIT]) || (data_done && !rw_q);
         xfer_done_q <= end_clean;
         frame_err_q <= end_err;
      end
   end

   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_we    = reg_we_q;
   assign reg_re    = reg_re_q;
   assign xfer_done = xfer_done_q;
   assign frame_err = frame_err_q;

endmodule
